// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command-frame parser and its helpers.
package uart_frame_parser_pkg;

  // Frame assembly states; IDLE waits for the header byte.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DH   = 3'd2,
    ST_GET_DL   = 3'd3,
    ST_GET_CHK  = 3'd4
  } frame_state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHK      = 2'b01;
  localparam logic [1:0] ERR_TO       = 2'b10;
  localparam int         FRAME_LEN    = 5;

  // One step of the running frame checksum (XOR over ADDR, DATA_H, DATA_L).
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout counter: restarts on clear, pulses expire for one cycle
// when LIMIT-1 idle cycles have elapsed; a same-cycle clear suppresses expiry.
module uart_byte_timeout #(
  parameter int LIMIT = 500000,
  parameter int W     = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [W-1:0] count_r;
  logic         expire_s;

  // Threshold detect; clear (a received byte) takes priority over expiry.
  always_comb begin
    if (enable && !clear && (count_r == W'(LIMIT - 1))) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Counter restarts on clear or expiry and otherwise counts while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clear || expire_s) begin
      count_r <= {W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = expire_s;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte command frames (HDR ADDR DATA_H DATA_L CHK) from the UART
// receiver byte stream and issues one register write per valid frame.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         TO_W        = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  frame_state_e state_r, state_nxt_s;
  logic [7:0]   addr_r, addr_nxt_s;
  logic [7:0]   dh_r, dh_nxt_s;
  logic [7:0]   dl_r, dl_nxt_s;
  logic [7:0]   chk_acc_r, chk_acc_nxt_s;
  logic         wr_en_r, wr_en_nxt_s;
  logic [7:0]   wr_addr_r, wr_addr_nxt_s;
  logic [15:0]  wr_data_r, wr_data_nxt_s;
  logic         frame_err_r, frame_err_nxt_s;
  logic [1:0]   err_code_r, err_code_nxt_s;
  logic         busy_r;
  logic         to_clear_s;
  logic         to_expire_s;

  // The timeout only runs while a frame is open; every byte restarts it.
  always_comb begin
    if (rx_done || (state_r == ST_IDLE)) begin
      to_clear_s = 1'b1;
    end else begin
      to_clear_s = 1'b0;
    end
  end

  uart_byte_timeout #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear_s),
    .enable (1'b1),
    .expire (to_expire_s)
  );

  // Next-state and output decode; a header inside a frame is plain data.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    dh_nxt_s        = dh_r;
    dl_nxt_s        = dl_r;
    chk_acc_nxt_s   = chk_acc_r;
    wr_en_nxt_s     = 1'b0;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    frame_err_nxt_s = 1'b0;
    err_code_nxt_s  = err_code_r;
    if (to_expire_s) begin
      state_nxt_s     = ST_IDLE;
      frame_err_nxt_s = 1'b1;
      err_code_nxt_s  = ERR_TO;
    end else if (rx_done) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == HDR_BYTE) begin
            state_nxt_s = ST_GET_ADDR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_GET_ADDR: begin
          addr_nxt_s    = rx_data;
          chk_acc_nxt_s = rx_data;
          state_nxt_s   = ST_GET_DH;
        end
        ST_GET_DH: begin
          dh_nxt_s      = rx_data;
          chk_acc_nxt_s = chk_step(chk_acc_r, rx_data);
          state_nxt_s   = ST_GET_DL;
        end
        ST_GET_DL: begin
          dl_nxt_s      = rx_data;
          chk_acc_nxt_s = chk_step(chk_acc_r, rx_data);
          state_nxt_s   = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          if (rx_data == chk_acc_r) begin
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = addr_r;
            wr_data_nxt_s = {dh_r, dl_r};
          end else begin
            frame_err_nxt_s = 1'b1;
            err_code_nxt_s  = ERR_CHK;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, frame fields and registered outputs; busy tracks the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= 8'h00;
      dh_r        <= 8'h00;
      dl_r        <= 8'h00;
      chk_acc_r   <= 8'h00;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 16'h0000;
      frame_err_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      dh_r        <= dh_nxt_s;
      dl_r        <= dl_nxt_s;
      chk_acc_r   <= chk_acc_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      err_code_r  <= err_code_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign frame_err = frame_err_r;
  assign err_code  = err_code_r;
  assign busy      = busy_r;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (data byte plus one-cycle done strobe).
- Assembles fixed 5-byte command frames: HDR, ADDR, DATA_H, DATA_L, CHK.
- On a frame with a valid checksum, issues a single-cycle register write (8-bit address, 16-bit data) to the board's control-register bank.
- Reports checksum errors and inter-byte timeouts.

Parameters:
- HDR_BYTE, 8'hAA, frame start marker.
- TIMEOUT_CYC, 500000, max clk cycles allowed between consecutive bytes of one frame (10 ms at 50 MHz).
- TO_W, 24, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, same domain as the UART receiver.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only in the cycle rx_done=1.
- rx_done  in  1  one-cycle strobe per received byte.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  8  write address; held until the next write.
- wr_data  out  16  write data {DATA_H, DATA_L}; held until the next write.
- frame_err  out  1  one-cycle error strobe.
- err_code  out  2  01 = checksum, 10 = timeout; held until the next error.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, timeout counter=0, all outputs 0, internal ADDR/DATA/CHK registers 0.
- States: IDLE, GET_ADDR, GET_DH, GET_DL, GET_CHK.
  - IDLE: rx_done and rx_data==HDR_BYTE -> GET_ADDR. Any other byte is dropped silently, with no error.
  - GET_ADDR: rx_done -> latch addr, chk_acc = rx_data -> GET_DH.
  - GET_DH: rx_done -> latch dh, chk_acc ^= rx_data -> GET_DL.
  - GET_DL: rx_done -> latch dl, chk_acc ^= rx_data -> GET_CHK.
  - GET_CHK: rx_done -> compare rx_data with chk_acc, then -> IDLE.
- Checksum = XOR of ADDR, DATA_H and DATA_L. HDR_BYTE is excluded.
- Match: wr_en=1 on the cycle after the CHK rx_done edge (latency 1 clk). wr_addr/wr_data update on that same edge.
- Mismatch: frame_err=1 and err_code=01 on the cycle after the CHK rx_done edge. wr_addr/wr_data are unchanged.
- Payload bytes equal to HDR_BYTE are treated as data; no resync on header inside a frame.
- Timeout counter:
  - Cleared on every rx_done and while in IDLE.
  - Otherwise increments by 1 per clk.
  - When it reaches TIMEOUT_CYC-1 with no rx_done in that cycle: -> IDLE, frame_err=1, err_code=10 next cycle, counter cleared.
  - rx_done in the same cycle as the timeout threshold: rx_done wins and no timeout is raised.
- Back-to-back frames: a new HDR may arrive on the very next rx_done after CHK. No idle gap is required.
- rx_done asserted for multiple consecutive cycles: each high cycle counts as a byte. The upstream guarantees single-cycle strobes; no edge detection is done here.
- wr_en and frame_err are never both 1 in the same cycle.
- rst mid-frame: frame is discarded, no wr_en, no frame_err, state=IDLE on the next cycle.
- busy is registered and equals (state != IDLE).

Decomposition:
- Shared uart package:
  - state enum encoding (5 states, 3-bit);
  - HDR_BYTE default;
  - err_code constants ERR_CHK=2'b01, ERR_TO=2'b10;
  - FRAME_LEN=5.
- One natural sub-module: uart_byte_timeout. It is the timeout counter (clear/enable inputs, expire output), reusable by the future TX-side ack logic.
- Everything else stays in the parser.

Test Plan:
- Frame AA 12 34 56 (CHK=12^34^56=70), bytes spaced 3000 clk -> single wr_en pulse, wr_addr=8'h12, wr_data=16'h3456, frame_err never asserted, busy low after completion.
- Same frame with CHK=71 -> frame_err pulse with err_code=01, no wr_en, wr_addr/wr_data keep previous values.
- Bytes 00 FF AA 01 02 03 00 (CHK=01^02^03=00) -> leading 00, FF ignored; wr_en with wr_addr=01, wr_data=0203.
- TIMEOUT_CYC=100: send AA 05, then silence -> frame_err with err_code=10 exactly 100 clk after the 05 strobe, busy drops. Then a full frame AA 05 00 01 04 -> wr_en, wr_addr=05, wr_data=0001.
- Byte strobe on exactly cycle TIMEOUT_CYC-1 after the previous byte -> no timeout, frame completes normally.
- Assert rst for 1 clk after AA 12 34 -> no output pulses, busy=0. Then AA 12 34 56 70 -> normal write.
